// File: rtl/nocr_pkg.sv
// nocr_pkg: shared packet layout, field positions and state/type enums for the NoC packet source
package nocr_pkg;
  localparam int PKT_W     = 13;
  localparam int ENTRY_W   = 12;
  localparam int VALID_BIT = 12;
  localparam int DATA_MSB  = 11;
  localparam int DATA_LSB  = 4;
  localparam int TYPE_MSB  = 3;
  localparam int TYPE_LSB  = 2;
  localparam int DEST_MSB  = 1;
  localparam int DEST_LSB  = 0;
  typedef enum logic [1:0] {DATA = 2'b00, CTRL = 2'b01, RESP = 2'b10, RSV = 2'b11} pack_type_e;
  typedef enum logic [1:0] {IDLE, SEND, GAP} src_state_e;
  function automatic logic [PKT_W-1:0] make_pkt(input logic [ENTRY_W-1:0] e);
    logic [PKT_W-1:0] p;
    p = '0;
    p[VALID_BIT] = 1'b1;
    p[DATA_MSB:DATA_LSB] = e[11:4];
    p[TYPE_MSB:TYPE_LSB] = e[3:2];
    p[DEST_MSB:DEST_LSB] = e[1:0];
    return p;
  endfunction
endpackage

// File: rtl/nocr_pkt_source_if.sv
// nocr_pkt_source_if: request handshake, router packet and status signals of the packet source
interface nocr_pkt_source_if import nocr_pkg::*; #(
  parameter int DEPTH = 4
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic [7:0]                 req_data;
  logic [1:0]                 req_type;
  logic [1:0]                 req_dest;
  logic [PKT_W-1:0]           packet;
  logic                       pkt_ack;
  logic                       busy;
  logic [$clog2(DEPTH):0]     count;
  logic                       drop_pulse;
  modport master (
    output req_valid, req_data, req_type, req_dest, pkt_ack,
    input  req_ready, packet, busy, count, drop_pulse
  );
  modport slave (
    input  req_valid, req_data, req_type, req_dest, pkt_ack,
    output req_ready, packet, busy, count, drop_pulse
  );
endinterface

// File: rtl/nocr_pkt_fifo.sv
// nocr_pkt_fifo: synchronous FIFO of formatted request entries with occupancy count
module nocr_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  // pointers wrap naturally at the power-of-two depth; a full FIFO ignores pushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // storage needs no reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/nocr_pkt_source.sv
// nocr_pkt_source: buffers requests and presents them as 13-bit router packets (NOCR_SRC_TIMEOUT_EN adds drop-on-timeout)
module nocr_pkt_source import nocr_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  nocr_pkt_source_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("nocr_pkt_source: DEPTH must be a power of two >= 2 and TIMEOUT in 1..255");
  end
  src_state_e         state_q, state_d;
  logic [PKT_W-1:0]   packet_q, packet_d;
  logic [ENTRY_W-1:0] head;
  logic               pop, full, empty;
  logic [CW-1:0]      count;
  nocr_pkt_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.req_valid),
    .data_i  ({bus.req_data, bus.req_type, bus.req_dest}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign bus.req_ready = !full;
  assign bus.count     = count;
  assign bus.busy      = (state_q != IDLE) || (count != '0);
  assign bus.packet    = packet_q;
`ifdef NOCR_SRC_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       drop_q, drop_d;
  // timeout counter and registered drop pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      drop_q <= drop_d;
    end
  end
  assign bus.drop_pulse = drop_q;
`else
  assign bus.drop_pulse = 1'b0;
`endif
  // FSM state and packet register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      packet_q <= '0;
    end else begin
      state_q  <= state_d;
      packet_q <= packet_d;
    end
  end
  // IDLE pops the head, SEND holds until ack (or timeout), GAP forces one zero cycle
  always_comb begin
    state_d  = state_q;
    packet_d = packet_q;
    pop      = 1'b0;
`ifdef NOCR_SRC_TIMEOUT_EN
    tmo_d    = tmo_q;
    drop_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        packet_d = '0;
        if (!empty) begin
          state_d  = SEND;
          pop      = 1'b1;
          packet_d = make_pkt(head);
`ifdef NOCR_SRC_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      SEND: begin
        if (bus.pkt_ack) begin
          state_d  = GAP;
          packet_d = '0;
        end
`ifdef NOCR_SRC_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT - 1)) begin
          state_d  = GAP;
          packet_d = '0;
          drop_d   = 1'b1;
        end else tmo_d = tmo_q + 8'd1;
`endif
      end
      GAP: begin
        state_d  = IDLE;
        packet_d = '0;
      end
      default: begin
        state_d  = IDLE;
        packet_d = '0;
      end
    endcase
  end
endmodule

// File: doc/nocr_pkt_source.md
# nocr_pkt_source

Ingress stage feeding the NoC router datapath. It accepts payload/type/destination requests from the local traffic source and buffers them in a small FIFO. It formats each one into the 13-bit router packet and presents it on the router input, holding it until the router controller acknowledges it. Optionally, an unacknowledged packet is dropped after a timeout.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 15, SEND cycles without ack before drop; only used when timeout is compiled in; 1..255
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept; high when count < DEPTH
- req_data  in  8  payload
- req_type  in  2  00 data, 01 control, 10 response, 11 reserve
- req_dest  in  2  target router id
- packet  out  13  {valid, data[7:0], type[1:0], dest[1:0]}
- pkt_ack  in  1  router consumed current packet; sampled only in SEND
- busy  out  1  state != IDLE or count != 0
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_pulse  out  1  one-cycle pulse when a packet is dropped on timeout

## Operation
- Enqueue on posedge when req_valid && req_ready. {req_data, req_type, req_dest} is written at the wr pointer.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- When full, req_ready = 0 and req_valid is ignored. Nothing is overwritten.
- Packet register format: packet[12]=1 while presenting, [11:4]=data, [3:2]=type, [1:0]=dest.
- FSM states:
  - IDLE: packet = 13'h0. If count > 0, go to SEND. At the same edge, pop the head into the packet register with bit12 = 1.
  - SEND: hold packet stable. If pkt_ack, go to GAP. If the timeout is reached, pulse drop_pulse and go to GAP.
  - GAP: packet = 13'h0 for exactly one cycle, then go to IDLE. This guarantees the router sees a deasserted packet[12] between packets.
- Simultaneous enqueue and pop in the same cycle: count is unchanged and both pointers advance.
- pkt_ack and timeout in the same cycle: ack wins and drop_pulse stays 0.
- pkt_ack in IDLE or GAP is ignored.
- Reset mid-operation clears everything. The FIFO contents and the in-flight packet are lost, with no drop_pulse.
- Reset values: packet = 0, req_ready = 1, busy = 0, count = 0, drop_pulse = 0, state = IDLE.

## Timing
- Enqueue to packet valid, with the FIFO empty and in IDLE: the request is enqueued at edge N, so count = 1 after N. The FSM pops at edge N+1, so packet[12] = 1 after N+1.
- Ack at edge M (in SEND): packet = 0 after M (GAP). The state is IDLE after M+1. The next packet is valid after M+2.
- Minimum of 3 cycles per packet (SEND, GAP, IDLE).
- Timeout counter: cleared on entry to SEND and incremented each SEND cycle without ack. drop_pulse is asserted in the cycle after the counter reaches TIMEOUT-1, i.e. TIMEOUT cycles after the packet is presented.
- All outputs are registered except req_ready and busy, which are combinational from registered state and count.

## Configuration
- NOCR_SRC_TIMEOUT_EN defined: timeout counter present. SEND exits on ack or on timeout with drop_pulse.
- NOCR_SRC_TIMEOUT_EN undefined: no counter. SEND waits indefinitely for pkt_ack. drop_pulse is tied to 0 and TIMEOUT is unused.

## Structure
- Package nocr_pkg holds:
  - PKT_W = 13
  - field positions VALID_BIT = 12, DATA_MSB/LSB = 11/4, TYPE_MSB/LSB = 3/2, DEST_MSB/LSB = 1/0
  - enum pack_type_e {DATA=2'b00, CTRL=2'b01, RESP=2'b10, RSV=2'b11}
  - enum src_state_e {IDLE, SEND, GAP}
- One sub-module, nocr_pkt_fifo: parameterised synchronous FIFO with 12-bit entries, push/pop, full/empty and count. The FSM and packet register stay in the top level.

## Test plan
- Reset, then one request data=8'hA5, type=01, dest=10 -> packet=13'h1A56 one cycle after count=1. It holds until pkt_ack, then 13'h0 for one cycle.
- Four back-to-back requests with pkt_ack=0, DEPTH=4 -> first popped to SEND. count reaches 3, and a fifth request fills to 4. req_ready=0 when count=4, and a sixth request is not accepted.
- Acks each issued one cycle after packet[12] rises -> packets appear in FIFO order. Each is separated by exactly one all-zero GAP cycle and one IDLE cycle.
- Timeout enabled, TIMEOUT=15, no ack -> drop_pulse=1 for exactly one cycle 15 cycles after the packet is presented, then GAP, then the next entry. Timeout disabled -> packet held for 100+ cycles.
- pkt_ack asserted on the timeout cycle -> no drop_pulse, normal GAP.
- Async reset deasserted then asserted mid-SEND with data=8'h3C, type=00, dest=11 (packet 13'h13C3) -> packet=0, count=0, req_ready=1 immediately without a clock edge.
